// File: rtl/stochastic_stream_decoder.sv
// Stochastic bitstream decoder: counts the ones in a framed stream of
// BIT_LENGTH bits and presents unipolar count and bipolar value on a
// valid/ready result port.
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   S_IDLE  | waiting for start; bit port closed, result holds last value
//   S_ACCUM | accepting bits, counting ones until the final bit arrives
//   S_HOLD  | result valid, held until the consumer takes it
module stochastic_stream_decoder #(
    parameter int BIT_LENGTH = 128,
    parameter int CNT_W      = $clog2(BIT_LENGTH + 1),
    parameter int IDX_W      = $clog2(BIT_LENGTH)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic                    bit_in,
    input  logic                    bit_valid,
    output logic                    bit_ready,
    output logic                    busy,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [CNT_W-1:0]        out_count,
    output logic signed [CNT_W:0]   out_bipolar
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ACCUM = 2'd1,
        S_HOLD  = 2'd2
    } state_t;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BIT_LENGTH - 1);
    localparam logic [CNT_W:0]   LEN_EXT  = (CNT_W + 1)'(BIT_LENGTH);

    state_t            state;
    logic [CNT_W-1:0]  ones;
    logic [IDX_W-1:0]  idx;
    logic              accept;
    logic              final_bit;
    logic [CNT_W-1:0]  count_next;
    logic [CNT_W:0]    bipolar_next;

    // Port status and next-result arithmetic, all derived from current state.
    // The bipolar value wraps modulo 2^(CNT_W+1), which is exact because the
    // true result always lies in [-BIT_LENGTH, +BIT_LENGTH].
    always_comb begin
        bit_ready    = (state == S_ACCUM);
        busy         = (state != S_IDLE);
        accept       = bit_ready && bit_valid;
        final_bit    = accept && (idx == LAST_IDX);
        count_next   = ones + CNT_W'(bit_in);
        bipolar_next = {count_next, 1'b0} - LEN_EXT;
    end

    // Control FSM with the ones/index counters and registered result.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_IDLE;
            ones        <= '0;
            idx         <= '0;
            out_count   <= '0;
            out_bipolar <= '0;
            out_valid   <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        state <= S_ACCUM;
                        ones  <= '0;
                        idx   <= '0;
                    end
                end
                S_ACCUM: begin
                    if (final_bit) begin
                        state       <= S_HOLD;
                        out_valid   <= 1'b1;
                        out_count   <= count_next;
                        out_bipolar <= $signed(bipolar_next);
                        ones        <= count_next;
                        idx         <= '0;
                    end else if (accept) begin
                        ones <= count_next;
                        idx  <= idx + 1'b1;
                    end
                end
                S_HOLD: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        if (start) begin
                            // back-to-back stream: no idle cycle in between
                            state <= S_ACCUM;
                            ones  <= '0;
                            idx   <= '0;
                        end else begin
                            state <= S_IDLE;
                        end
                    end
                end
                default: begin
                    state     <= S_IDLE;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_stochastic_stream_decoder.sv
// Self-checking bench for stochastic_stream_decoder: expected results are
// computed from the driven bits, queued, and compared when the result appears.
module tb_stochastic_stream_decoder;

    localparam int BL = 128;
    localparam int CW = $clog2(BL + 1);

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 start;
    logic                 bit_in;
    logic                 bit_valid;
    logic                 bit_ready;
    logic                 busy;
    logic                 out_valid;
    logic                 out_ready;
    logic [CW-1:0]        out_count;
    logic signed [CW:0]   out_bipolar;

    typedef struct {
        int cnt;
        int bip;
    } exp_t;

    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;

    stochastic_stream_decoder #(.BIT_LENGTH(BL)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .bit_in      (bit_in),
        .bit_valid   (bit_valid),
        .bit_ready   (bit_ready),
        .busy        (busy),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_count   (out_count),
        .out_bipolar (out_bipolar)
    );

    always #5 clk = ~clk;

    // 0: zeros, 1: ones, 2: alternating 1,0,..., 3: forty ones then zeros
    function automatic logic pattern_bit(input int mode, input int i);
        case (mode)
            0:       return 1'b0;
            1:       return 1'b1;
            2:       return (i % 2 == 0);
            default: return (i < 40);
        endcase
    endfunction

    function automatic exp_t pop_expected();
        exp_t e;
        e.cnt = -1;
        e.bip = -1000;
        if (sb.size() != 0) e = sb.pop_front();
        return e;
    endfunction

    task automatic begin_stream();
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    // Drives one full stream starting at the first ACCUM cycle. Returns the
    // number of cycles up to and including the one where out_valid should
    // be high, and whether out_valid was seen high too early.
    task automatic drive_stream(input int mode, input bit gaps,
                                output int ncyc, output bit early);
        int cnt;
        cnt   = 0;
        ncyc  = 0;
        early = 1'b0;
        for (int i = 0; i < BL; i++) begin
            if (gaps) begin
                @(negedge clk);
                if (out_valid) early = 1'b1;
                bit_valid = 1'b0;
                bit_in    = 1'b1;
                ncyc++;
            end
            @(negedge clk);
            if (out_valid) early = 1'b1;
            bit_in    = pattern_bit(mode, i);
            bit_valid = 1'b1;
            cnt      += int'(bit_in);
            ncyc++;
        end
        @(negedge clk);
        bit_valid = 1'b0;
        bit_in    = 1'b0;
        ncyc++;
        sb.push_back('{cnt, 2 * cnt - BL});
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; bit_in = 1'b0; bit_valid = 1'b0; out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0 || busy !== 1'b0 || bit_ready !== 1'b0) begin
            errors++;
            $display("FAIL reset_flags: valid=%b busy=%b ready=%b want 0 0 0", out_valid, busy, bit_ready);
        end
        checks++;
        if (out_count !== '0 || out_bipolar !== '0) begin
            errors++;
            $display("FAIL reset_result: count=%0d bip=%0d want 0 0", out_count, out_bipolar);
        end
        // bits offered in IDLE must be ignored
        bit_in = 1'b1; bit_valid = 1'b1;
        repeat (4) @(negedge clk);
        checks++;
        if (bit_ready !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL idle_ignore: ready=%b busy=%b want 0 0", bit_ready, busy);
        end
        bit_in = 1'b0; bit_valid = 1'b0;
    endtask

    task automatic test_all_ones();
        int   ncyc;
        bit   early;
        exp_t e;
        out_ready = 1'b1;
        begin_stream();
        checks++;
        if (bit_ready !== 1'b1 || busy !== 1'b1) begin
            errors++;
            $display("FAIL accum_flags: ready=%b busy=%b want 1 1", bit_ready, busy);
        end
        drive_stream(1, 1'b0, ncyc, early);
        checks++;
        if (early !== 1'b0 || out_valid !== 1'b1) begin
            errors++;
            $display("FAIL ones_valid: early=%b valid=%b want 0 1", early, out_valid);
        end
        checks++;
        if (ncyc != BL + 1) begin
            errors++;
            $display("FAIL ones_latency: got %0d cycles want %0d", ncyc, BL + 1);
        end
        e = pop_expected();
        checks++;
        if (int'(out_count) !== e.cnt || out_count !== CW'(BL)) begin
            errors++;
            $display("FAIL ones_count: got %0d want %0d", out_count, e.cnt);
        end
        checks++;
        if (int'(out_bipolar) !== e.bip) begin
            errors++;
            $display("FAIL ones_bipolar: got %0d want %0d", out_bipolar, e.bip);
        end
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0 || busy !== 1'b0 || int'(out_count) !== e.cnt) begin
            errors++;
            $display("FAIL ones_release: valid=%b busy=%b count=%0d want 0 0 %0d", out_valid, busy, out_count, e.cnt);
        end
    endtask

    task automatic test_patterns();
        int   modes[2] = '{0, 2};
        int   ncyc;
        bit   early;
        exp_t e;
        out_ready = 1'b1;
        foreach (modes[k]) begin
            begin_stream();
            drive_stream(modes[k], 1'b0, ncyc, early);
            e = pop_expected();
            checks++;
            if (out_valid !== 1'b1 || early !== 1'b0) begin
                errors++;
                $display("FAIL pattern%0d_valid: valid=%b early=%b want 1 0", modes[k], out_valid, early);
            end
            checks++;
            if (int'(out_count) !== e.cnt) begin
                errors++;
                $display("FAIL pattern%0d_count: got %0d want %0d", modes[k], out_count, e.cnt);
            end
            checks++;
            if (int'(out_bipolar) !== e.bip) begin
                errors++;
                $display("FAIL pattern%0d_bipolar: got %0d want %0d", modes[k], out_bipolar, e.bip);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_gaps();
        int   ncyc;
        bit   early;
        exp_t e;
        out_ready = 1'b1;
        begin_stream();
        drive_stream(1, 1'b1, ncyc, early);
        e = pop_expected();
        checks++;
        if (out_valid !== 1'b1 || early !== 1'b0 || ncyc != 2 * BL + 1) begin
            errors++;
            $display("FAIL gaps_latency: valid=%b early=%b cycles=%0d want 1 0 %0d", out_valid, early, ncyc, 2 * BL + 1);
        end
        checks++;
        if (int'(out_count) !== e.cnt || int'(out_bipolar) !== e.bip) begin
            errors++;
            $display("FAIL gaps_result: count=%0d bip=%0d want %0d %0d", out_count, out_bipolar, e.cnt, e.bip);
        end
        @(negedge clk);
    endtask

    task automatic test_hold();
        int   ncyc;
        bit   early;
        bit   bad;
        exp_t e;
        out_ready = 1'b0;
        begin_stream();
        drive_stream(3, 1'b0, ncyc, early);
        e = pop_expected();
        bad = 1'b0;
        for (int c = 0; c < 10; c++) begin
            bit_in    = c[0];
            bit_valid = ~c[0];
            start     = c[1];
            @(negedge clk);
            if (out_valid !== 1'b1 || int'(out_count) !== e.cnt || int'(out_bipolar) !== e.bip
                || bit_ready !== 1'b0 || busy !== 1'b1) bad = 1'b1;
        end
        checks++;
        if (bad) begin
            errors++;
            $display("FAIL hold_stable: valid=%b count=%0d bip=%0d ready=%b want 1 %0d %0d 0",
                     out_valid, out_count, out_bipolar, bit_ready, e.cnt, e.bip);
        end
        start = 1'b0; bit_valid = 1'b0; bit_in = 1'b0; out_ready = 1'b1;
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0 || busy !== 1'b0 || int'(out_count) !== e.cnt) begin
            errors++;
            $display("FAIL hold_release: valid=%b busy=%b count=%0d want 0 0 %0d", out_valid, busy, out_count, e.cnt);
        end
    endtask

    task automatic test_back_to_back();
        int   ncyc;
        bit   early;
        exp_t e;
        out_ready = 1'b0;
        begin_stream();
        drive_stream(3, 1'b0, ncyc, early);
        e = pop_expected();
        checks++;
        if (int'(out_count) !== e.cnt) begin
            errors++;
            $display("FAIL b2b_first: got %0d want %0d", out_count, e.cnt);
        end
        start = 1'b1; out_ready = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || bit_ready !== 1'b1 || busy !== 1'b1) begin
            errors++;
            $display("FAIL b2b_restart: valid=%b ready=%b busy=%b want 0 1 1", out_valid, bit_ready, busy);
        end
        drive_stream(1, 1'b0, ncyc, early);
        e = pop_expected();
        checks++;
        if (out_valid !== 1'b1 || ncyc != BL + 1 || int'(out_count) !== e.cnt || int'(out_bipolar) !== e.bip) begin
            errors++;
            $display("FAIL b2b_second: valid=%b cycles=%0d count=%0d bip=%0d want 1 %0d %0d %0d",
                     out_valid, ncyc, out_count, out_bipolar, BL + 1, e.cnt, e.bip);
        end
        @(negedge clk);
    endtask

    task automatic test_rst_mid();
        int   ncyc;
        bit   early;
        exp_t e;
        out_ready = 1'b1;
        begin_stream();
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            bit_in    = (i < 30);
            bit_valid = 1'b1;
        end
        @(negedge clk);
        bit_valid = 1'b0; bit_in = 1'b0;
        rst = 1'b1; start = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0; start = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || busy !== 1'b0 || bit_ready !== 1'b0) begin
            errors++;
            $display("FAIL rst_mid_flags: valid=%b busy=%b ready=%b want 0 0 0", out_valid, busy, bit_ready);
        end
        checks++;
        if (out_count !== '0 || out_bipolar !== '0) begin
            errors++;
            $display("FAIL rst_mid_result: count=%0d bip=%0d want 0 0", out_count, out_bipolar);
        end
        begin_stream();
        drive_stream(0, 1'b0, ncyc, early);
        e = pop_expected();
        checks++;
        if (out_valid !== 1'b1 || int'(out_count) !== e.cnt || int'(out_bipolar) !== e.bip) begin
            errors++;
            $display("FAIL rst_mid_discard: valid=%b count=%0d bip=%0d want 1 %0d %0d",
                     out_valid, out_count, out_bipolar, e.cnt, e.bip);
        end
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_all_ones();
        test_patterns();
        test_gaps();
        test_hold();
        test_back_to_back();
        test_rst_mid();
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: %0d left want 0", sb.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
